// File: rtl/mc_core.sv
// Multicycle MIPS-32 core on a single unified memory port: one instruction
// moves through FETCH/DECODE/... states, reusing one ALU and one memory port.
module mc_core #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned MEM_AW   = 32
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic [31:0]       pc,
   output logic              instr_done,
   output logic              illegal
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned NREG = 32;
   localparam int unsigned RAW  = 5;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] F_ADD = 6'h20;
   localparam logic [5:0] F_SUB = 6'h22;
   localparam logic [5:0] F_AND = 6'h24;
   localparam logic [5:0] F_OR  = 6'h25;
   localparam logic [5:0] F_SLT = 6'h2A;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      EXEC, ALUWB, IEXEC, IWB, BRANCH, JUMP
   } state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   ir_q, ir_d;
   logic [XLEN-1:0]   a_q, a_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic [XLEN-1:0]   alu_q, alu_d;
   logic [XLEN-1:0]   mdr_q, mdr_d;
   logic [XLEN-1:0]   rf_q [NREG];
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [MEM_AW-1:0] addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic              done_q, done_d;
   logic              ill_q, ill_d;

   logic              rf_we;
   logic [RAW-1:0]    rf_waddr;
   logic [XLEN-1:0]   rf_wdata;
   logic              accept;
   logic              taken;

   logic [5:0]        opcode, funct;
   logic [RAW-1:0]    rs, rt, rd;
   logic [XLEN-1:0]   signimm, zeroimm;

   assign opcode  = ir_q[31:26];
   assign rs      = ir_q[25:21];
   assign rt      = ir_q[20:16];
   assign rd      = ir_q[15:11];
   assign funct   = ir_q[5:0];
   assign signimm = {{16{ir_q[15]}}, ir_q[15:0]};
   assign zeroimm = {16'h0000, ir_q[15:0]};
   assign accept  = req_q & mem_ready;
   assign taken   = (opcode == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);

   // State and datapath registers; every register clears on reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         alu_q   <= '0;
         mdr_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         ill_q   <= 1'b0;
         for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         alu_q   <= alu_d;
         mdr_q   <= mdr_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
         ill_q   <= ill_d;
         if (rf_we && (rf_waddr != '0)) rf_q[rf_waddr] <= rf_wdata;
      end
   end

   // Controller: next state, datapath updates and registered port values.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      alu_d    = alu_q;
      mdr_d    = mdr_q;
      done_d   = 1'b0;
      ill_d    = 1'b0;
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;

      case (state_q)
         FETCH: begin
            if (accept) begin
               ir_d    = mem_rdata;
               pc_d    = pc_q + 32'd4;
               state_d = DECODE;
            end
         end
         DECODE: begin
            a_d   = rf_q[rs];
            b_d   = rf_q[rt];
            alu_d = pc_q + {signimm[29:0], 2'b00};
            case (opcode)
               OP_LW, OP_SW:             state_d = MEMADR;
               OP_RTYPE:                 state_d = EXEC;
               OP_ADDI, OP_ANDI, OP_ORI: state_d = IEXEC;
               OP_BEQ, OP_BNE:           state_d = BRANCH;
               OP_J:                     state_d = JUMP;
               default: begin
                  ill_d   = 1'b1;
                  state_d = FETCH;
               end
            endcase
         end
         MEMADR: begin
            alu_d   = a_q + signimm;
            state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
         end
         MEMRD: begin
            if (accept) begin
               mdr_d   = mem_rdata;
               state_d = MEMWB;
            end
         end
         MEMWB: begin
            rf_we    = 1'b1;
            rf_waddr = rt;
            rf_wdata = mdr_q;
            done_d   = 1'b1;
            state_d  = FETCH;
         end
         MEMWR: begin
            if (accept) begin
               done_d  = 1'b1;
               state_d = FETCH;
            end
         end
         EXEC: begin
            state_d = ALUWB;
            case (funct)
               F_ADD:   alu_d = a_q + b_q;
               F_SUB:   alu_d = a_q - b_q;
               F_AND:   alu_d = a_q & b_q;
               F_OR:    alu_d = a_q | b_q;
               F_SLT:   alu_d = {31'd0, ($signed(a_q) < $signed(b_q))};
               default: begin
                  ill_d   = 1'b1;
                  state_d = FETCH;
               end
            endcase
         end
         ALUWB: begin
            rf_we    = 1'b1;
            rf_waddr = rd;
            rf_wdata = alu_q;
            done_d   = 1'b1;
            state_d  = FETCH;
         end
         IEXEC: begin
            state_d = IWB;
            case (opcode)
               OP_ANDI: alu_d = a_q & zeroimm;
               OP_ORI:  alu_d = a_q | zeroimm;
               default: alu_d = a_q + signimm;
            endcase
         end
         IWB: begin
            rf_we    = 1'b1;
            rf_waddr = rt;
            rf_wdata = alu_q;
            done_d   = 1'b1;
            state_d  = FETCH;
         end
         BRANCH: begin
            if (taken) pc_d = alu_q;
            done_d  = 1'b1;
            state_d = FETCH;
         end
         JUMP: begin
            pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
            done_d  = 1'b1;
            state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase

      // Request fields derive from the next state so they stay frozen while waiting.
      req_d   = (state_d == FETCH) || (state_d == MEMRD) || (state_d == MEMWR);
      we_d    = (state_d == MEMWR);
      addr_d  = (state_d == FETCH) ? pc_d[MEM_AW-1:0] : alu_d[MEM_AW-1:0];
      wdata_d = b_d;
   end

   assign mem_req    = req_q;
   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign pc         = pc_q;
   assign instr_done = done_q;
   assign illegal    = ill_q;

endmodule

// File: tb/tb_mc_core.sv
// Directed bench for mc_core: a behavioural memory with programmable wait
// states serves small hand-assembled programs; results are checked per task.
module tb_mc_core;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        reset;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic [31:0] pc;
   logic        instr_done;
   logic        illegal;

   mc_core #(.RESET_PC(RESET_PC), .MEM_AW(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .pc         (pc),
      .instr_done (instr_done),
      .illegal    (illegal)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] rom     [256];
   logic [31:0] ram     [256];
   bit          ram_vld [256];
   int          delay = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          done_cyc [16];
   int          illegal_cnt = 0;
   int          wr_cnt = 0;
   logic [31:0] wr_addr = '0;
   logic [31:0] wr_data = '0;
   int          stab_err = 0;
   int          n_stall = 0;
   logic [31:0] rd_log [$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // Memory model acting on the falling edge: wait states, store log, fetch log.
   initial begin : mem_model
      int          wcnt;
      bit          pend;
      logic [31:0] p_addr, p_wdata;
      logic        p_we;
      logic [7:0]  idx;
      wcnt = 0; pend = 1'b0; p_addr = '0; p_wdata = '0; p_we = 1'b0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset) begin
            for (int i = 0; i < 256; i++) ram_vld[i] = 1'b0;
            done_cnt = 0; illegal_cnt = 0; wr_cnt = 0; n_stall = 0;
            rd_log.delete();
            wcnt = 0; pend = 1'b0;
            mem_ready = 1'b0;
         end else begin
            if (instr_done) begin
               if (done_cnt < 16) done_cyc[done_cnt] = cyc;
               done_cnt++;
            end
            if (illegal) illegal_cnt++;
            if (mem_req) begin
               if (pend && ((mem_addr !== p_addr) || (mem_we !== p_we) ||
                            (mem_we && (mem_wdata !== p_wdata))))
                  stab_err++;
               p_addr = mem_addr; p_we = mem_we; p_wdata = mem_wdata;
               if (wcnt >= delay) begin
                  idx = mem_addr[9:2];
                  mem_ready = 1'b1;
                  mem_rdata = ram_vld[idx] ? ram[idx] : rom[idx];
                  if (mem_we) begin
                     ram[idx] = mem_wdata;
                     ram_vld[idx] = 1'b1;
                     wr_cnt++;
                     wr_addr = mem_addr;
                     wr_data = mem_wdata;
                  end else begin
                     rd_log.push_back(mem_addr);
                  end
                  wcnt = 0;
                  pend = 1'b0;
               end else begin
                  mem_ready = 1'b0;
                  n_stall++;
                  wcnt++;
                  pend = 1'b1;
               end
            end else begin
               mem_ready = 1'b0;
               wcnt = 0;
               pend = 1'b0;
            end
         end
      end
   end

   function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] ej(input logic [25:0] index);
      return {6'h02, index};
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = 32'h0;
   endtask

   task automatic do_reset(input int dly);
      @(negedge clk);
      #2 reset = 1'b0;
      delay = dly;
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
   endtask

   task automatic wait_done(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         #2;
         if (done_cnt >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      clear_rom();
      rom[0] = ej(26'h0);
      @(negedge clk);
      #2;
      n_checks++;
      if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
      n_checks++;
      if (pc !== RESET_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, RESET_PC); end
      n_checks++;
      if ({instr_done, illegal} !== 2'b00) begin
         n_fail++; $display("FAIL reset_pulses: got %b%b want 00", instr_done, illegal);
      end
      reset = 1'b1;
      @(negedge clk);
      #2;
      n_checks++;
      if ({mem_req, mem_we} !== 2'b10 || mem_addr !== RESET_PC) begin
         n_fail++;
         $display("FAIL first_fetch: req=%b we=%b addr=%h want req=1 we=0 addr=%h",
                  mem_req, mem_we, mem_addr, RESET_PC);
      end
   endtask

   task automatic test_alu();
      bit ok;
      clear_rom();
      rom[0] = ei(6'h08, 5'd0, 5'd1, 16'h0005);
      rom[1] = ei(6'h08, 5'd0, 5'd2, 16'hFFFD);
      rom[2] = er(5'd1, 5'd2, 5'd3, 6'h20);
      rom[3] = ej(26'h3);
      do_reset(0);
      wait_done(3, 100, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL alu_timeout: done=%0d want 3", done_cnt); end
      n_checks++;
      if (dut.rf_q[1] !== 32'd5 || dut.rf_q[2] !== 32'hFFFF_FFFD) begin
         n_fail++; $display("FAIL alu_addi: r1=%h r2=%h want 00000005 fffffffd", dut.rf_q[1], dut.rf_q[2]);
      end
      n_checks++;
      if (dut.rf_q[3] !== 32'd2) begin n_fail++; $display("FAIL alu_add: r3=%h want 00000002", dut.rf_q[3]); end
      n_checks++;
      if ((done_cyc[1] - done_cyc[0]) != 4 || (done_cyc[2] - done_cyc[1]) != 4) begin
         n_fail++;
         $display("FAIL alu_cpi: intervals %0d %0d want 4 4",
                  done_cyc[1] - done_cyc[0], done_cyc[2] - done_cyc[1]);
      end
   endtask

   task automatic test_mem_wait();
      bit ok;
      clear_rom();
      rom[0]  = ej(26'h10);
      rom[2]  = 32'hDEAD_BEEF;
      rom[16] = ei(6'h08, 5'd0, 5'd3, 16'h0002);
      rom[17] = ei(6'h2B, 5'd0, 5'd3, 16'h0008);
      rom[18] = ei(6'h23, 5'd0, 5'd4, 16'h0008);
      rom[19] = ej(26'h13);
      do_reset(3);
      wait_done(4, 300, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL mem_timeout: done=%0d want 4", done_cnt); end
      n_checks++;
      if (wr_cnt != 1 || wr_addr !== 32'h8 || wr_data !== 32'h2) begin
         n_fail++;
         $display("FAIL mem_store: writes=%0d addr=%h data=%h want 1 00000008 00000002",
                  wr_cnt, wr_addr, wr_data);
      end
      n_checks++;
      if (dut.rf_q[4] !== 32'h2) begin n_fail++; $display("FAIL mem_load: r4=%h want 00000002", dut.rf_q[4]); end
      n_checks++;
      if (stab_err != 0 || n_stall < 18) begin
         n_fail++; $display("FAIL mem_stable: changes=%0d stalls=%0d want 0 >=18", stab_err, n_stall);
      end
      n_checks++;
      if ((done_cyc[2] - done_cyc[1]) != 10 || (done_cyc[3] - done_cyc[2]) != 11) begin
         n_fail++;
         $display("FAIL mem_latency: sw=%0d lw=%0d want 10 11",
                  done_cyc[2] - done_cyc[1], done_cyc[3] - done_cyc[2]);
      end
      delay = 0;
   endtask

   task automatic test_branch();
      bit ok;
      clear_rom();
      rom[0] = ei(6'h08, 5'd0, 5'd0, 16'h0007);
      rom[1] = ei(6'h08, 5'd0, 5'd8, 16'h0001);
      rom[2] = ei(6'h08, 5'd0, 5'd0, 16'h0000);
      rom[3] = ei(6'h08, 5'd0, 5'd0, 16'h0000);
      rom[4] = ei(6'h04, 5'd0, 5'd0, 16'h0003);
      rom[5] = ei(6'h08, 5'd0, 5'd9, 16'h0001);
      rom[8] = ej(26'h8);
      do_reset(0);
      wait_done(5, 100, ok);
      n_checks++;
      if (!ok || mem_req !== 1'b1 || mem_addr !== 32'h20) begin
         n_fail++; $display("FAIL beq_taken: ok=%b req=%b addr=%h want 1 1 00000020", ok, mem_req, mem_addr);
      end
      n_checks++;
      if (done_cyc[4] - done_cyc[3] != 3) begin
         n_fail++; $display("FAIL beq_cpi: got %0d want 3", done_cyc[4] - done_cyc[3]);
      end
      repeat (10) @(negedge clk);
      n_checks++;
      if (dut.rf_q[0] !== 32'h0 || dut.rf_q[8] !== 32'h1 || dut.rf_q[9] !== 32'h0) begin
         n_fail++;
         $display("FAIL beq_regs: r0=%h r8=%h r9=%h want 0 1 0", dut.rf_q[0], dut.rf_q[8], dut.rf_q[9]);
      end
      clear_rom();
      rom[0] = ej(26'h4);
      rom[4] = ei(6'h05, 5'd0, 5'd0, 16'h0003);
      rom[5] = ej(26'h5);
      do_reset(0);
      wait_done(2, 100, ok);
      n_checks++;
      if (!ok || mem_addr !== 32'h14 || pc !== 32'h14) begin
         n_fail++; $display("FAIL bne_not_taken: ok=%b addr=%h pc=%h want 1 00000014 00000014", ok, mem_addr, pc);
      end
   endtask

   task automatic test_jump_imm();
      bit ok;
      clear_rom();
      rom[0]  = ei(6'h0D, 5'd0, 5'd5, 16'hFFFF);
      rom[1]  = ei(6'h08, 5'd0, 5'd1, 16'h0005);
      rom[2]  = ei(6'h08, 5'd0, 5'd2, 16'hFFFD);
      rom[3]  = er(5'd2, 5'd1, 5'd6, 6'h2A);
      rom[4]  = er(5'd1, 5'd2, 5'd7, 6'h2A);
      rom[5]  = ej(26'h40);
      rom[64] = ej(26'h40);
      do_reset(0);
      wait_done(7, 200, ok);
      n_checks++;
      if (!ok || mem_addr !== 32'h100 || pc !== 32'h100) begin
         n_fail++; $display("FAIL jump_target: ok=%b addr=%h pc=%h want 1 00000100 00000100", ok, mem_addr, pc);
      end
      n_checks++;
      if (dut.rf_q[5] !== 32'h0000_FFFF) begin n_fail++; $display("FAIL ori_zext: r5=%h want 0000ffff", dut.rf_q[5]); end
      n_checks++;
      if (dut.rf_q[6] !== 32'h1 || dut.rf_q[7] !== 32'h0) begin
         n_fail++; $display("FAIL slt_signed: r6=%h r7=%h want 1 0", dut.rf_q[6], dut.rf_q[7]);
      end
      n_checks++;
      if ((done_cyc[6] - done_cyc[5]) != 3 || (done_cyc[4] - done_cyc[3]) != 4) begin
         n_fail++;
         $display("FAIL jump_cpi: j=%0d slt=%0d want 3 4", done_cyc[6] - done_cyc[5], done_cyc[4] - done_cyc[3]);
      end
   endtask

   task automatic test_illegal();
      bit ok;
      clear_rom();
      rom[0] = ei(6'h08, 5'd0, 5'd1, 16'h0005);
      rom[1] = 32'hFC00_0000;
      rom[2] = er(5'd1, 5'd2, 5'd7, 6'h00);
      rom[3] = ej(26'h3);
      do_reset(0);
      wait_done(2, 100, ok);
      n_checks++;
      if (!ok || illegal_cnt != 2) begin
         n_fail++; $display("FAIL illegal_count: ok=%b pulses=%0d want 1 2", ok, illegal_cnt);
      end
      n_checks++;
      if (dut.rf_q[1] !== 32'h5 || dut.rf_q[7] !== 32'h0 || dut.rf_q[2] !== 32'h0) begin
         n_fail++;
         $display("FAIL illegal_regs: r1=%h r2=%h r7=%h want 5 0 0", dut.rf_q[1], dut.rf_q[2], dut.rf_q[7]);
      end
      n_checks++;
      if (rd_log.size() < 4 || rd_log[1] !== 32'h4 || rd_log[2] !== 32'h8 || rd_log[3] !== 32'hC) begin
         n_fail++;
         $display("FAIL illegal_pc: fetches=%0d want >=4 sequential 0,4,8,c", rd_log.size());
      end
   endtask

   task automatic test_reset_midwait();
      bit ok;
      bit seen;
      int nz;
      clear_rom();
      rom[0] = ei(6'h08, 5'd0, 5'd1, 16'h0005);
      rom[1] = ei(6'h23, 5'd0, 5'd2, 16'h0080);
      rom[32] = 32'h1234_5678;
      do_reset(6);
      wait_done(1, 100, ok);
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         #2;
         if (mem_req && !mem_we && mem_addr == 32'h80) begin seen = 1'b1; break; end
      end
      n_checks++;
      if (!ok || !seen) begin n_fail++; $display("FAIL midwait_reach: done=%b memrd=%b want 1 1", ok, seen); end
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (mem_req !== 1'b0 || instr_done !== 1'b0 || illegal !== 1'b0 || pc !== RESET_PC) begin
         n_fail++;
         $display("FAIL midwait_reset: req=%b done=%b ill=%b pc=%h want 0 0 0 %h",
                  mem_req, instr_done, illegal, pc, RESET_PC);
      end
      nz = 0;
      for (int i = 0; i < 32; i++) if (dut.rf_q[i] !== 32'h0) nz++;
      n_checks++;
      if (nz != 0) begin n_fail++; $display("FAIL midwait_rf_clear: nonzero=%0d want 0", nz); end
      delay = 0;
      @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      #2;
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== RESET_PC) begin
         n_fail++; $display("FAIL midwait_refetch: req=%b addr=%h want 1 %h", mem_req, mem_addr, RESET_PC);
      end
      wait_done(1, 50, ok);
      n_checks++;
      if (!ok || dut.rf_q[1] !== 32'h5 || dut.rf_q[2] !== 32'h0) begin
         n_fail++;
         $display("FAIL midwait_rerun: ok=%b r1=%h r2=%h want 1 5 0", ok, dut.rf_q[1], dut.rf_q[2]);
      end
   endtask

   initial begin
      reset = 1'b0;
      test_reset();
      test_alu();
      test_mem_wait();
      test_branch();
      test_jump_imm();
      test_illegal();
      test_reset_midwait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
